// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
package seg_pkg;

  localparam int unsigned DIGITS  = 6;
  localparam logic [5:0]  SEL_OFF = 6'h3F;
  localparam logic [7:0]  SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Leading-zero blank mask: digit i blanks while it and every digit above it are zero.
  // Index 0 always stays visible.
  function automatic logic [5:0] lz_mask(input logic [23:0] data, input logic lz_en);
    logic [5:0] m;
    logic       blanking;
    m        = '0;
    blanking = lz_en;
    for (int i = 5; i >= 1; i--) begin
      blanking = blanking && (data[i*4 +: 4] == 4'h0);
      m[i]     = blanking;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_hex2seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  // Table lookup; dp is handled by the caller.
  always_comb begin
    seg7 = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment driver with per-frame input latching,
// inter-digit blanking, leading-zero suppression and decimal points.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic [5:0]  dp_in,
  input  logic        lz_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  // 20 bits covers the largest legal SCAN_DIV of 2^20.
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] data_q, data_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  mask_q, mask_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic        fd_q, fd_d;

  logic        tick;
  logic        frame_wrap;
  logic [3:0]  nib;
  logic [6:0]  dec;

  assign tick       = (cnt_q == 20'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx_q == 3'(DIGITS - 1));
  assign nib        = data_q[{idx_q, 2'b00} +: 4];

  hex2seg u_hex2seg (
    .nib  (nib),
    .seg7 (dec)
  );

  // Prescaler, digit index and once-per-frame shadow load.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 20'd1;
    idx_d  = idx_q;
    data_d = data_q;
    dp_d   = dp_q;
    mask_d = mask_q;
    if (tick) begin
      idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
    if (frame_wrap) begin
      data_d = data_in;
      dp_d   = dp_in;
      mask_d = lz_mask(data_in, lz_en);
    end
  end

  // Output values derived from the current slot; registered one cycle later.
  always_comb begin
    fd_d  = frame_wrap;
    sel_d = (cnt_q < 20'(BLANK_CYC)) ? SEL_OFF : ~(6'b000001 << idx_q);
    seg_d = mask_q[idx_q] ? SEG_OFF : {~dp_q[idx_q], dec};
  end

  // State and output registers; reset parks one tick before a frame start.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 20'(SCAN_DIV - 1);
      idx_q  <= 3'(DIGITS - 1);
      data_q <= '0;
      dp_q   <= '0;
      mask_q <= '0;
      sel_q  <= SEL_OFF;
      seg_q  <= SEG_OFF;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      dp_q   <= dp_d;
      mask_q <= mask_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      fd_q   <= fd_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with SCAN_DIV = 4, BLANK_CYC = 1.
module tb_seg_scan;

  logic        clk_1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_in = '0;
  logic [5:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // {sel, seg, frame_done} expected per sampled cycle.
  logic [14:0] sb[$];

  seg_scan #(
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk_1      (clk_1),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk_1 = ~clk_1;

  // Called at a negedge where frame_done is high; checks the 24 cycles that follow.
  // Optionally changes data_in mid-frame at cycle chg_at to verify anti-tearing.
  task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                             input logic [7:0] e5, input int chg_at, input logic [23:0] chg_data);
    logic [7:0]  exp_seg [6];
    logic [5:0]  es;
    logic [14:0] exp_v;
    logic [14:0] got;
    int          slot;
    exp_seg = '{e0, e1, e2, e3, e4, e5};
    for (int k = 0; k < 24; k++) begin
      slot = k / 4;
      es   = ((k % 4) < 1) ? 6'h3F : ~(6'b000001 << slot);
      sb.push_back({es, exp_seg[slot], (k == 23)});
      if (k == chg_at) data_in = chg_data;
      @(negedge clk_1);
      exp_v = sb.pop_front();
      got   = {sel, seg, frame_done};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s cyc%0d: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 name, k, got[14:9], got[8:1], got[0], exp_v[14:9], exp_v[8:1], exp_v[0]);
      end
    end
  endtask

  // Set new inputs, then advance to the next frame_done so they are latched.
  task automatic apply(input logic [23:0] d, input logic [5:0] dp, input logic lz);
    int n;
    data_in = d;
    dp_in   = dp;
    lz_en   = lz;
    n = 0;
    do begin
      @(negedge clk_1);
      n++;
    end while (!frame_done && n < 50);
    if (!frame_done) begin
      vectors++;
      miscompares++;
      $display("FAIL apply_wait: frame_done not seen, got %b want 1", frame_done);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({sel, seg, frame_done} !== {6'h3F, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got sel=%h seg=%h fd=%b, want sel=3f seg=ff fd=0",
               name, sel, seg, frame_done);
    end
  endtask

  task automatic check_first_pulse(input string name);
    @(negedge clk_1);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got frame_done=%b want 1", name, frame_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = 24'($urandom);
      dp_in   = 6'($urandom);
      lz_en   = 1'($urandom);
      @(negedge clk_1);
      check_reset_outputs("reset_hold");
    end
    data_in = 24'h012345;
    dp_in   = 6'h00;
    lz_en   = 1'b0;
    rst_n   = 1'b1;
    check_first_pulse("reset_first_frame_done");
  endtask

  task automatic test_digits;
    check_frame("digits_f1", 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, -1, 24'h0);
    check_frame("digits_f2", 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, -1, 24'h0);
  endtask

  task automatic test_anti_tear;
    // Change lands during slot 2; the rest of the frame must still show 012345.
    check_frame("tear_old", 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 9, 24'h123450);
    check_frame("tear_new", 8'hC0, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, -1, 24'h0);
  endtask

  task automatic test_leading_zero;
    apply(24'h000A05, 6'h00, 1'b1);
    check_frame("lz_000a05", 8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, -1, 24'h0);
    apply(24'h000000, 6'h00, 1'b1);
    check_frame("lz_all_zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, -1, 24'h0);
    apply(24'h000000, 6'h00, 1'b0);
    check_frame("nolz_all_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 24'h0);
  endtask

  task automatic test_decimal_point;
    apply(24'h000000, 6'h01, 1'b0);
    check_frame("dp_idx0", 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 24'h0);
  endtask

  task automatic test_reset_mid_frame;
    apply(24'h012345, 6'h00, 1'b0);
    // Walk into slot 3, cycle 2 of the frame.
    for (int k = 0; k < 15; k++) @(negedge clk_1);
    data_in = 24'h9A0B1C;
    dp_in   = 6'h00;
    lz_en   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset_async");
    @(negedge clk_1);
    check_reset_outputs("mid_reset_hold");
    rst_n = 1'b1;
    check_first_pulse("mid_reset_first_frame_done");
    check_frame("mid_reset_fresh", 8'hC6, 8'hF9, 8'h83, 8'hC0, 8'h88, 8'h90, -1, 24'h0);
  endtask

  initial begin
    test_reset;
    test_digits;
    test_anti_tear;
    test_leading_zero;
    test_decimal_point;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
